// File: rtl/systolic_pkg.sv
// Shared constants and state encoding for the 8x8 systolic feeder.
package systolic_pkg;

    localparam int N            = 8;
    localparam int LANE_W       = 8;
    localparam int VEC_W        = N * LANE_W;
    localparam int FLUSH_CYCLES = 16;
    localparam int FLUSH_W      = $clog2(FLUSH_CYCLES);
    localparam int BEAT_W       = $clog2(N);

    typedef enum logic [1:0] {
        ST_FEED  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

endpackage

// File: rtl/systolic_skew_line.sv
// Enable-gated delay line: q shows the value loaded DEPTH enabled cycles ago.
module systolic_skew_line #(
    parameter int DEPTH  = 1,
    parameter int LANE_W = 8
) (
    input  logic              CLOCK,
    input  logic              reset,
    input  logic              en,
    input  logic [LANE_W-1:0] d,
    output logic [LANE_W-1:0] q
);

    logic [LANE_W-1:0] taps [DEPTH];

    // Shift the taps only on enabled cycles so stalls freeze the skew.
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else if (en) begin
            taps[0] <= d;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign q = taps[DEPTH-1];

endmodule

// File: rtl/systolic_feeder_8x8.sv
// Feeds skewed operand vectors into an 8x8 output-stationary array, flushes
// the pipeline with zeros, drains the 8 result rows as a stream, then clears.
//
// Handshakes: a beat transfers on a rising CLOCK edge where valid && ready;
// valid never depends on ready, and the payload is held while valid && !ready.
module systolic_feeder_8x8
    import systolic_pkg::*;
(
    input  logic             CLOCK,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [VEC_W-1:0] s_a,
    input  logic [VEC_W-1:0] s_b,
    input  logic             s_last,
    output logic [VEC_W-1:0] arr_in_col,
    output logic [VEC_W-1:0] arr_in_row,
    output logic [VEC_W-1:0] arr_in_data,
    output logic             arr_input_valid,
    output logic             arr_mult_over,
    output logic             arr_clear,
    input  logic [VEC_W-1:0] arr_out_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [VEC_W-1:0] m_data,
    output logic             m_last,
    output state_t           dbg_state
);

    state_t              state;
    state_t              next_state;
    logic [FLUSH_W-1:0]  flush_cnt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic                skew_load;
    logic [VEC_W-1:0]    col_d;
    logic [VEC_W-1:0]    row_d;

    // State register plus the flush/beat counters and the registered clear pulse.
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            state     <= ST_FEED;
            flush_cnt <= '0;
            beat_cnt  <= '0;
            arr_clear <= 1'b0;
        end else begin
            state     <= next_state;
            arr_clear <= (next_state == ST_CLEAR);
            if (state == ST_FLUSH)
                flush_cnt <= flush_cnt + 1'b1;
            else
                flush_cnt <= '0;
            if (state == ST_DRAIN) begin
                if (m_ready) beat_cnt <= beat_cnt + 1'b1;
            end else begin
                beat_cnt <= '0;
            end
        end
    end

    // Next-state and per-state drive of the stream and array controls.
    always_comb begin
        next_state      = state;
        s_ready         = 1'b0;
        skew_load       = 1'b0;
        arr_input_valid = 1'b0;
        arr_mult_over   = 1'b0;
        m_valid         = 1'b0;
        m_last          = 1'b0;
        m_data          = '0;
        case (state)
            ST_FEED: begin
                s_ready         = 1'b1;
                skew_load       = 1'b1;
                arr_input_valid = s_valid;
                if (s_valid && s_last) next_state = ST_FLUSH;
            end
            ST_FLUSH: begin
                arr_input_valid = 1'b1;
                if (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1)) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                arr_mult_over   = 1'b1;
                m_valid         = 1'b1;
                m_data          = arr_out_data;
                m_last          = (beat_cnt == BEAT_W'(N - 1));
                arr_input_valid = m_ready && (beat_cnt != BEAT_W'(N - 1));
                if (m_ready && (beat_cnt == BEAT_W'(N - 1))) next_state = ST_CLEAR;
            end
            ST_CLEAR: begin
                next_state = ST_FEED;
            end
            default: begin
                next_state = ST_FEED;
            end
        endcase
    end

    // Outside FEED zeros are pushed so the lines empty themselves.
    assign col_d       = skew_load ? s_a : '0;
    assign row_d       = skew_load ? s_b : '0;
    assign arr_in_data = '0;
    assign dbg_state   = state;

    // Lane k is delayed k+1 advancing cycles to form the diagonal wavefront.
    for (genvar k = 0; k < N; k++) begin : g_lane
        systolic_skew_line #(.DEPTH(k + 1), .LANE_W(LANE_W)) u_col (
            .CLOCK (CLOCK),
            .reset (reset),
            .en    (arr_input_valid),
            .d     (col_d[k*LANE_W +: LANE_W]),
            .q     (arr_in_col[k*LANE_W +: LANE_W])
        );
        systolic_skew_line #(.DEPTH(k + 1), .LANE_W(LANE_W)) u_row (
            .CLOCK (CLOCK),
            .reset (reset),
            .en    (arr_input_valid),
            .d     (row_d[k*LANE_W +: LANE_W]),
            .q     (arr_in_row[k*LANE_W +: LANE_W])
        );
    end

endmodule

// File: tb/tb_systolic_feeder_8x8.sv
// Bench for systolic_feeder_8x8 with a behavioural 8x8 array attached.
`timescale 1ns/1ps
module tb_systolic_feeder_8x8;
    import systolic_pkg::*;

    logic        CLOCK;
    logic        reset;
    logic        s_valid, s_ready, s_last;
    logic [63:0] s_a, s_b;
    logic [63:0] arr_in_col, arr_in_row, arr_in_data;
    logic        arr_input_valid, arr_mult_over, arr_clear;
    logic [63:0] arr_out_data;
    logic        m_valid, m_ready, m_last;
    logic [63:0] m_data;
    state_t      dbg_state;

    int total = 0;
    int bad   = 0;

    logic [63:0] va[$];
    logic [63:0] vb[$];
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic        got_last_q[$];
    int          flush_seen, drain_err, stall_seen, timeout;
    int          skew_err, gap_err, acc_err;
    logic [3:0]  clr_state;
    logic [2:0]  clr_after;

    // ---------------- clock / reset ----------------
    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    systolic_feeder_8x8 dut (
        .CLOCK           (CLOCK),
        .reset           (reset),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_a             (s_a),
        .s_b             (s_b),
        .s_last          (s_last),
        .arr_in_col      (arr_in_col),
        .arr_in_row      (arr_in_row),
        .arr_in_data     (arr_in_data),
        .arr_input_valid (arr_input_valid),
        .arr_mult_over   (arr_mult_over),
        .arr_clear       (arr_clear),
        .arr_out_data    (arr_out_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .m_last          (m_last),
        .dbg_state       (dbg_state)
    );

    // ---------------- behavioural 8x8 output-stationary array ----------------
    logic [7:0] pe_a   [8][8];
    logic [7:0] pe_b   [8][8];
    logic [7:0] pe_acc [8][8];

    function automatic logic [7:0] a_in(int i, int j);
        if (j == 0) return arr_in_col[8*i +: 8];
        return pe_a[i][j-1];
    endfunction

    function automatic logic [7:0] b_in(int i, int j);
        if (i == 0) return arr_in_row[8*j +: 8];
        return pe_b[i-1][j];
    endfunction

    always @(posedge CLOCK or posedge reset) begin
        if (reset || arr_clear) begin
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++) begin
                    pe_a[i][j]   <= 8'h00;
                    pe_b[i][j]   <= 8'h00;
                    pe_acc[i][j] <= 8'h00;
                end
        end else if (arr_input_valid) begin
            if (!arr_mult_over) begin
                for (int i = 0; i < 8; i++)
                    for (int j = 0; j < 8; j++) begin
                        pe_a[i][j]   <= a_in(i, j);
                        pe_b[i][j]   <= b_in(i, j);
                        pe_acc[i][j] <= pe_acc[i][j] + a_in(i, j) * b_in(i, j);
                    end
            end else begin
                for (int i = 0; i < 7; i++)
                    for (int j = 0; j < 8; j++) pe_acc[i][j] <= pe_acc[i+1][j];
                for (int j = 0; j < 8; j++) pe_acc[7][j] <= 8'h00;
            end
        end
    end

    always_comb begin
        arr_out_data = '0;
        for (int j = 0; j < 8; j++) arr_out_data[8*j +: 8] = pe_acc[0][j];
    end

    // ---------------- reference: result[i][j] = sum_k a_k[i]*b_k[j] mod 256 ----------------
    task automatic build_expected();
        logic [63:0] ta, tb, row;
        int unsigned s;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            row = '0;
            for (int j = 0; j < 8; j++) begin
                s = 0;
                for (int k = 0; k < va.size(); k++) begin
                    ta = va[k];
                    tb = vb[k];
                    s += int'(ta[8*i +: 8]) * int'(tb[8*j +: 8]);
                end
                row[8*j +: 8] = 8'(s % 256);
            end
            exp_q.push_back(row);
        end
    endtask

    task automatic rand_vectors(input int k);
        va.delete();
        vb.delete();
        for (int n = 0; n < k; n++) begin
            va.push_back({$urandom, $urandom});
            vb.push_back({$urandom, $urandom});
        end
    endtask

    // ---------------- driver tasks (start and end at posedge+1) ----------------
    task automatic feed(input int gap_at, input int gap_len);
        logic [63:0] ha, hb;
        int idx;
        skew_err = 0; gap_err = 0; acc_err = 0;
        for (int n = 0; n < va.size(); n++) begin
            s_valid = 1'b1;
            s_a     = va[n];
            s_b     = vb[n];
            s_last  = (n == va.size() - 1);
            @(negedge CLOCK);
            if (!s_ready || !arr_input_valid) acc_err++;
            for (int k = 0; k < 8; k++) begin
                idx = n - k - 1;
                ha  = (idx >= 0) ? va[idx] : 64'h0;
                hb  = (idx >= 0) ? vb[idx] : 64'h0;
                if (arr_in_col[8*k +: 8] !== ha[8*k +: 8]) skew_err++;
                if (arr_in_row[8*k +: 8] !== hb[8*k +: 8]) skew_err++;
            end
            @(posedge CLOCK); #1;
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (n == gap_at) begin
                repeat (gap_len) begin
                    @(negedge CLOCK);
                    if (arr_input_valid || !s_ready) gap_err++;
                    @(posedge CLOCK); #1;
                end
            end
        end
    endtask

    task automatic drain(input int stall_beat, input int stall_len, input bit rand_ready,
                         input int stop_at);
        int cyc, stall_left;
        logic [63:0] held;
        bit holding;
        cyc = 0; stall_left = stall_len; held = '0; holding = 0;
        got_q.delete(); got_last_q.delete();
        flush_seen = 0; drain_err = 0; stall_seen = 0; timeout = 0;
        clr_state = '0; clr_after = '0;
        while (got_q.size() < stop_at && timeout == 0) begin
            if (m_valid && got_q.size() == stall_beat && stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                m_ready = 1'($urandom_range(0, 1));
            end else begin
                m_ready = 1'b1;
            end
            @(negedge CLOCK);
            if (!m_valid && !s_ready && arr_input_valid && !arr_mult_over) flush_seen++;
            if (arr_mult_over !== m_valid) drain_err++;
            if (m_valid && !m_ready) begin
                if (arr_input_valid) drain_err++;
                if (holding && m_data !== held) drain_err++;
                held = m_data;
                holding = 1;
                stall_seen++;
            end else if (m_valid && m_ready) begin
                if (holding && m_data !== held) drain_err++;
                holding = 0;
                if (arr_input_valid !== (got_q.size() < 7)) drain_err++;
                got_q.push_back(m_data);
                got_last_q.push_back(m_last);
            end
            @(posedge CLOCK); #1;
            cyc++;
            if (cyc > 600) timeout = 1;
        end
        m_ready = 1'b1;
        if (stop_at == 8 && timeout == 0) begin
            @(negedge CLOCK);
            clr_state = {arr_clear, arr_input_valid, m_valid, s_ready};
            @(posedge CLOCK); #1;
            @(negedge CLOCK);
            clr_after = {arr_clear, s_ready, m_valid};
            @(posedge CLOCK); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        total++;
        if ({s_ready, m_valid, m_last, arr_input_valid, arr_mult_over, arr_clear} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 100000",
                     {s_ready, m_valid, m_last, arr_input_valid, arr_mult_over, arr_clear});
        end
        total++;
        if ({m_data, arr_in_col, arr_in_row, arr_in_data} !== 256'h0) begin
            bad++;
            $display("FAIL reset_data: got %h %h %h %h want all 0", m_data, arr_in_col, arr_in_row, arr_in_data);
        end
        total++;
        if (dbg_state !== ST_FEED) begin
            bad++;
            $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_FEED);
        end
        @(posedge CLOCK); #1;
        reset = 1'b0;
        @(posedge CLOCK); #1;
    endtask

    task automatic test_k1();
        va.delete(); vb.delete();
        va.push_back({8{8'h01}});
        vb.push_back({8{8'h02}});
        feed(-1, 0);
        drain(-1, 0, 1'b0, 8);
        total++;
        if (got_q.size() != 8) begin bad++; $display("FAIL k1_beats: got %0d want 8", got_q.size()); end
        for (int b = 0; b < got_q.size(); b++) begin
            total++;
            if (got_q[b] !== {8{8'h02}}) begin
                bad++; $display("FAIL k1_data beat%0d: got %h want %h", b, got_q[b], {8{8'h02}});
            end
            total++;
            if (got_last_q[b] !== (b == 7)) begin
                bad++; $display("FAIL k1_last beat%0d: got %b want %b", b, got_last_q[b], (b == 7));
            end
        end
        total++;
        if (flush_seen != FLUSH_CYCLES) begin bad++; $display("FAIL k1_flush: got %0d want %0d", flush_seen, FLUSH_CYCLES); end
        total++;
        if (clr_state !== 4'b1000) begin bad++; $display("FAIL k1_clear: got %b want 1000", clr_state); end
        total++;
        if (clr_after !== 3'b010) begin bad++; $display("FAIL k1_after_clear: got %b want 010", clr_after); end
        total++;
        if (skew_err != 0 || acc_err != 0 || drain_err != 0) begin
            bad++; $display("FAIL k1_ctrl: got skew=%0d acc=%0d drain=%0d want 0", skew_err, acc_err, drain_err);
        end
    endtask

    task automatic test_k3_lanes();
        logic [63:0] a, b, want;
        for (int l = 0; l < 8; l++) begin a[8*l +: 8] = 8'(l + 1); b[8*l +: 8] = 8'(l + 1); end
        va.delete(); vb.delete();
        repeat (3) begin va.push_back(a); vb.push_back(b); end
        feed(-1, 0);
        drain(-1, 0, 1'b0, 8);
        total++;
        if (got_q.size() != 8) begin bad++; $display("FAIL k3_beats: got %0d want 8", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            for (int j = 0; j < 8; j++) want[8*j +: 8] = 8'((3 * (i + 1) * (j + 1)) % 256);
            total++;
            if (got_q[i] !== want) begin
                bad++; $display("FAIL k3_data beat%0d: got %h want %h", i, got_q[i], want);
            end
        end
        total++;
        if (skew_err != 0) begin bad++; $display("FAIL k3_skew: got %0d errors want 0", skew_err); end
    endtask

    task automatic test_stall_gap();
        logic [63:0] first[$];
        rand_vectors(4);
        feed(-1, 0);
        drain(-1, 0, 1'b0, 8);
        first = got_q;
        feed(1, 5);
        build_expected();
        drain(-1, 0, 1'b0, 8);
        total++;
        if (got_q.size() != 8 || first.size() != 8) begin
            bad++; $display("FAIL gap_beats: got %0d/%0d want 8/8", first.size(), got_q.size());
        end
        for (int b = 0; b < got_q.size() && b < first.size(); b++) begin
            total++;
            if (got_q[b] !== exp_q[b] || first[b] !== exp_q[b]) begin
                bad++; $display("FAIL gap_data beat%0d: got %h/%h want %h", b, first[b], got_q[b], exp_q[b]);
            end
        end
        total++;
        if (gap_err != 0) begin bad++; $display("FAIL gap_hold: got %0d bad gap cycles want 0", gap_err); end
        total++;
        if (skew_err != 0) begin bad++; $display("FAIL gap_skew: got %0d errors want 0", skew_err); end
    endtask

    task automatic test_k300();
        va.delete(); vb.delete();
        repeat (300) begin va.push_back({8{8'hFF}}); vb.push_back({8{8'hFF}}); end
        feed(-1, 0);
        drain(-1, 0, 1'b0, 8);
        total++;
        if (got_q.size() != 8) begin bad++; $display("FAIL k300_beats: got %0d want 8", got_q.size()); end
        for (int b = 0; b < got_q.size(); b++) begin
            total++;
            if (got_q[b] !== {8{8'h2C}}) begin
                bad++; $display("FAIL k300_data beat%0d: got %h want %h", b, got_q[b], {8{8'h2C}});
            end
        end
    endtask

    task automatic test_mready_stall();
        rand_vectors(5);
        feed(-1, 0);
        build_expected();
        drain(3, 4, 1'b0, 8);
        total++;
        if (got_q.size() != 8) begin bad++; $display("FAIL mstall_beats: got %0d want 8", got_q.size()); end
        for (int b = 0; b < got_q.size(); b++) begin
            total++;
            if (got_q[b] !== exp_q[b] || got_last_q[b] !== (b == 7)) begin
                bad++; $display("FAIL mstall_data beat%0d: got %h/%b want %h/%b", b, got_q[b], got_last_q[b], exp_q[b], (b == 7));
            end
        end
        total++;
        if (stall_seen != 4 || drain_err != 0) begin
            bad++; $display("FAIL mstall_hold: got stalls=%0d errs=%0d want 4/0", stall_seen, drain_err);
        end
        total++;
        if (clr_state !== 4'b1000) begin bad++; $display("FAIL mstall_clear: got %b want 1000", clr_state); end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            rand_vectors($urandom_range(1, 12));
            feed($urandom_range(0, 3), $urandom_range(0, 4));
            build_expected();
            drain(-1, 0, 1'b1, 8);
            total++;
            if (got_q.size() != 8) begin bad++; $display("FAIL b2b_beats run%0d: got %0d want 8", r, got_q.size()); end
            for (int b = 0; b < got_q.size(); b++) begin
                total++;
                if (got_q[b] !== exp_q[b] || got_last_q[b] !== (b == 7)) begin
                    bad++; $display("FAIL b2b_data run%0d beat%0d: got %h/%b want %h/%b", r, b, got_q[b], got_last_q[b], exp_q[b], (b == 7));
                end
            end
            total++;
            if (drain_err != 0 || skew_err != 0 || gap_err != 0 || acc_err != 0 || flush_seen != FLUSH_CYCLES) begin
                bad++; $display("FAIL b2b_ctrl run%0d: got drain=%0d skew=%0d gap=%0d acc=%0d flush=%0d want 0/0/0/0/16",
                                r, drain_err, skew_err, gap_err, acc_err, flush_seen);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        int stray;
        rand_vectors(3);
        feed(-1, 0);
        drain(-1, 0, 1'b0, 2);
        total++;
        if (got_q.size() != 2 || !m_valid) begin
            bad++; $display("FAIL rst_setup: got beats=%0d m_valid=%b want 2/1", got_q.size(), m_valid);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({s_ready, m_valid, m_last, arr_input_valid, arr_mult_over, arr_clear} !== 6'b100000 ||
            m_data !== 64'h0 || arr_in_col !== 64'h0 || arr_in_row !== 64'h0) begin
            bad++; $display("FAIL rst_outputs: got ctrl=%b data=%h want 100000/0",
                            {s_ready, m_valid, m_last, arr_input_valid, arr_mult_over, arr_clear}, m_data);
        end
        total++;
        if (dbg_state !== ST_FEED) begin bad++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_FEED); end
        @(posedge CLOCK); #1;
        reset = 1'b0;
        stray = 0;
        repeat (5) begin
            @(negedge CLOCK);
            if (m_valid) stray++;
        end
        @(posedge CLOCK); #1;
        total++;
        if (stray != 0) begin bad++; $display("FAIL rst_stray_valid: got %0d want 0", stray); end
        rand_vectors(1);
        feed(-1, 0);
        build_expected();
        drain(-1, 0, 1'b0, 8);
        total++;
        if (got_q.size() != 8) begin bad++; $display("FAIL rst_rerun_beats: got %0d want 8", got_q.size()); end
        for (int b = 0; b < got_q.size(); b++) begin
            total++;
            if (got_q[b] !== exp_q[b]) begin
                bad++; $display("FAIL rst_rerun beat%0d: got %h want %h", b, got_q[b], exp_q[b]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_k1();
        test_k3_lanes();
        test_stall_gap();
        test_k300();
        test_mready_stall();
        test_back_to_back();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
